branch_cmp_predictor: RTL
=========================

Name: branch_cmp_predictor

Overview:
- ID-stage branch condition evaluator with a parametrised pattern history table (PHT) of saturating counters.
- IF stage does a registered lookup and gets a predicted direction. ID stage resolves the real condition, trains the PHT and flags mispredicts one cycle later.
- Generalises the existing combinational comparator in three ways: operand width, table depth, and a coded condition field instead of full instruction decode.

Parameters:
- DATA_W, 32: operand width for the rs/rt compare.
- PHT_DEPTH, 64: number of PHT entries; must be a power of two, minimum 4.
- CTR_W, 2: saturating counter width; minimum 2.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset (asserted at 0)
- lk_valid  in  1  IF lookup request
- lk_pc  in  32  fetch PC
- lk_taken  out  1  registered prediction for the previous cycle's lookup
- init_done  out  1  PHT initialisation complete
- rs_valid  in  1  ID branch resolve request
- rs_stall  in  1  ID stalled; resolve ignored
- rs_cond  in  4  condition code (package enum)
- rs_pc  in  32  branch PC
- rs_data_rs  in  DATA_W  forwarded rs value
- rs_data_rt  in  DATA_W  forwarded rt value
- rs_pred_taken  in  1  prediction carried down from IF
- cmp  out  1  combinational condition result
- mispredict  out  1  registered; high for one cycle after a wrong prediction
- mp_pc  out  32  registered rs_pc of the mispredicted branch

Behaviour:
- Condition codes and cmp (signed, two's complement):
  - EQ: rs==rt
  - NE: rs!=rt
  - GEZ: rs[MSB]==0
  - GTZ: rs[MSB]==0 and rs!=0
  - LEZ: rs[MSB]==1 or rs==0
  - LTZ: rs[MSB]==1
  - RTZ: rt==0
  - RTNZ: rt!=0
  - ALW: 1
  - NEV: 0
  - Undefined codes give cmp=0 and are treated as non-branch.
- Index: pc[IDX_W+1:2], where IDX_W = log2(PHT_DEPTH).
- Predicted taken when the counter MSB is 1.
- Reset (async, reset=0):
  - lk_taken=0, mispredict=0, mp_pc=0, init_done=0.
  - FSM goes to INIT with the init pointer at 0.
- FSM states:
  - INIT: writes weakly-not-taken (MSB 0, all other bits 1; 01 for CTR_W=2) into one entry per cycle, pointer 0..PHT_DEPTH-1. After writing the last entry → RUN and init_done=1 on the next cycle. Takes PHT_DEPTH cycles.
  - RUN: normal operation; stays in RUN until reset.
  - Reset asserted mid-INIT or mid-RUN restarts INIT from pointer 0.
- Lookup:
  - lk_taken is updated every cycle with lk_valid ? PHT[idx(lk_pc)].MSB : 0.
  - During INIT, lk_taken is forced to 0.
- Resolve fires when rs_valid & ~rs_stall & init_done & rs_cond ∈ {EQ,NE,GEZ,GTZ,LEZ,LTZ}:
  - Counter at idx(rs_pc) increments (saturating at all-ones) if cmp=1, otherwise decrements (saturating at 0).
  - mispredict <= (cmp != rs_pred_taken).
  - mp_pc <= rs_pc.
- Non-firing cycles (stall, ~rs_valid, INIT, or ALW/NEV/RTZ/RTNZ/undefined):
  - mispredict <= 0; mp_pc holds; no PHT write.
  - cmp is still driven combinationally.
- Simultaneous lookup and update to the same index: the lookup reads the pre-update value (read-before-write).
- Only one write port. During INIT, resolves are dropped.
- Latency: cmp 0 cycles; lk_taken 1 cycle; mispredict/mp_pc 1 cycle; PHT update visible to lookups issued the cycle after the resolve.

Optional Feature:
- Macro: BRANCH_STATS_EN.
- Defined:
  - Adds outputs stat_resolved[31:0] and stat_mispred[31:0].
  - Each is incremented on a firing resolve and on a firing resolve with a mispredict, respectively.
  - Both saturate at 0xFFFFFFFF and reset asynchronously to 0.
  - Adds input stat_clr, which zeroes both counters synchronously; stat_clr wins over a same-cycle increment.
- Undefined: these ports and counters do not exist; the core behaviour is identical.

Decomposition:
- Shared package holds:
  - the 4-bit condition enum: EQ=0, NE=1, GEZ=2, GTZ=3, LEZ=4, LTZ=5, RTZ=6, RTNZ=7, ALW=8, NEV=9;
  - the FSM state enum (INIT, RUN);
  - a helper that maps a condition to "trainable".
- Sub-module bcp_cond_eval: pure combinational evaluation of cond/rs/rt → cmp, parametrised by DATA_W.
- PHT array, INIT FSM, and the mispredict register stay in the top module.

Test Plan:
- Reset, then count cycles until init_done → exactly 64 cycles after reset release. Any lookup during INIT → lk_taken=0.
- After init: BEQ pc=0x00003000, rs=rt=5, pred=0 → cmp=1; next cycle mispredict=1, mp_pc=0x00003000. A following lookup at 0x00003000 → lk_taken=1 (counter 01→10).
- Same branch resolved not-taken 3 times from 11 → counter 10, 01, 00, saturating at 00. A 4th not-taken resolve leaves 00 and, with pred=0, mispredict=0.
- rs_valid=1 and rs_stall=1 with GTZ rs=0x7FFFFFFF → cmp=1, no PHT change, mispredict stays 0. LTZ rs=0x80000000 → cmp=1.
- Lookup and resolve to index 5 (pc 0x14 and 0x114 with DEPTH=64) in the same cycle → lk_taken reflects the old counter; the next lookup reflects the new one.
- With BRANCH_STATS_EN: 10 resolves including 3 mispredicts → stat_resolved=10, stat_mispred=3. stat_clr asserted together with a resolve → both counters 0.

Source files
------------

// File: rtl/branch_cmp_predictor_pkg.sv
// Shared types for the ID-stage branch comparator / PHT predictor.
// Latency: n/a (types, constants and a pure helper only).
// Backpressure: n/a.
package branch_cmp_predictor_pkg;

   // Coded branch condition carried from decode; codes 10..15 are non-branch.
   typedef enum logic [3:0] {
      COND_EQ   = 4'd0,
      COND_NE   = 4'd1,
      COND_GEZ  = 4'd2,
      COND_GTZ  = 4'd3,
      COND_LEZ  = 4'd4,
      COND_LTZ  = 4'd5,
      COND_RTZ  = 4'd6,
      COND_RTNZ = 4'd7,
      COND_ALW  = 4'd8,
      COND_NEV  = 4'd9
   } cond_e;

   // Table initialisation sequencer states.
   typedef enum logic {
      ST_INIT = 1'b0,
      ST_RUN  = 1'b1
   } state_e;

   // Only the data-dependent conditions train the PHT; unconditional,
   // rt-only and undefined codes never touch it.
   function automatic logic cond_trainable(input logic [3:0] cond);
      return (cond <= 4'(COND_LTZ));
   endfunction

endpackage

// File: rtl/bcp_cond_eval.sv
// Combinational branch condition evaluator: cond/rs/rt -> cmp (two's complement).
// Latency: 0 cycles, purely combinational.
// Backpressure: none; the result is always driven.
module bcp_cond_eval
   import branch_cmp_predictor_pkg::*;
#(
   parameter int DATA_W = 32
) (
   input  logic [3:0]        cond,
   input  logic [DATA_W-1:0] rs,
   input  logic [DATA_W-1:0] rt,
   output logic              cmp
);

   logic rs_neg;
   logic rs_zero;
   logic rt_zero;

   assign rs_neg  = rs[DATA_W-1];
   assign rs_zero = (rs == '0);
   assign rt_zero = (rt == '0);

   // Decode the condition code; undefined codes evaluate to not-taken.
   always_comb begin
      cmp = 1'b0;
      case (cond)
         COND_EQ:   cmp = (rs == rt);
         COND_NE:   cmp = (rs != rt);
         COND_GEZ:  cmp = ~rs_neg;
         COND_GTZ:  cmp = ~rs_neg & ~rs_zero;
         COND_LEZ:  cmp = rs_neg | rs_zero;
         COND_LTZ:  cmp = rs_neg;
         COND_RTZ:  cmp = rt_zero;
         COND_RTNZ: cmp = ~rt_zero;
         COND_ALW:  cmp = 1'b1;
         COND_NEV:  cmp = 1'b0;
         default:   cmp = 1'b0;
      endcase
   end

endmodule

// File: rtl/branch_cmp_predictor.sv
// ID-stage branch resolver with a PHT of saturating counters; optional stats via BRANCH_STATS_EN.
// Latency: cmp 0 cycles; lk_taken, mispredict and mp_pc 1 cycle; init takes PHT_DEPTH cycles.
// Backpressure: rs_stall drops the resolve (no training); resolves are dropped until init_done.
module branch_cmp_predictor
   import branch_cmp_predictor_pkg::*;
#(
   parameter int DATA_W    = 32,
   parameter int PHT_DEPTH = 64,
   parameter int CTR_W     = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              lk_valid,
   input  logic [31:0]       lk_pc,
   output logic              lk_taken,
   output logic              init_done,
   input  logic              rs_valid,
   input  logic              rs_stall,
   input  logic [3:0]        rs_cond,
   input  logic [31:0]       rs_pc,
   input  logic [DATA_W-1:0] rs_data_rs,
   input  logic [DATA_W-1:0] rs_data_rt,
   input  logic              rs_pred_taken,
   output logic              cmp,
   output logic              mispredict,
   output logic [31:0]       mp_pc
`ifdef BRANCH_STATS_EN
   ,
   input  logic              stat_clr,
   output logic [31:0]       stat_resolved,
   output logic [31:0]       stat_mispred
`endif
);

   localparam int IDX_W = $clog2(PHT_DEPTH);
   localparam logic [CTR_W-1:0] CTR_WNT  = {1'b0, {(CTR_W-1){1'b1}}};
   localparam logic [CTR_W-1:0] CTR_MAX  = '1;
   localparam logic [CTR_W-1:0] CTR_ONE  = CTR_W'(1);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(PHT_DEPTH - 1);

   state_e           state_q;
   state_e           state_d;
   logic [IDX_W-1:0] init_ptr_q;
   logic [CTR_W-1:0] pht [PHT_DEPTH];

   logic [IDX_W-1:0] lk_idx;
   logic [IDX_W-1:0] rs_idx;
   logic             fire;
   logic             wrong;
   logic             pht_we;
   logic [IDX_W-1:0] pht_widx;
   logic [CTR_W-1:0] pht_wdat;
   logic [CTR_W-1:0] ctr_cur;
   logic [CTR_W-1:0] ctr_nxt;
   logic             unused_pc_bits;

   assign lk_idx = lk_pc[IDX_W+1:2];
   assign rs_idx = rs_pc[IDX_W+1:2];
   // Word-aligned PCs: low bits and bits above the index never select an entry.
   assign unused_pc_bits = ^{lk_pc[31:IDX_W+2], lk_pc[1:0]};

   bcp_cond_eval #(
      .DATA_W (DATA_W)
   ) u_cond_eval (
      .cond (rs_cond),
      .rs   (rs_data_rs),
      .rt   (rs_data_rt),
      .cmp  (cmp)
   );

   assign fire    = rs_valid & ~rs_stall & init_done & cond_trainable(rs_cond);
   assign wrong   = (cmp != rs_pred_taken);
   assign ctr_cur = pht[rs_idx];

   // Saturating counter step toward the resolved direction.
   always_comb begin
      ctr_nxt = ctr_cur;
      if (cmp) begin
         if (ctr_cur != CTR_MAX) ctr_nxt = ctr_cur + CTR_ONE;
      end else begin
         if (ctr_cur != '0) ctr_nxt = ctr_cur - CTR_ONE;
      end
   end

   // Sequencer state, init pointer and init_done flag.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= ST_INIT;
         init_ptr_q <= '0;
         init_done  <= 1'b0;
      end else begin
         state_q   <= state_d;
         init_done <= (state_d == ST_RUN);
         if (state_q == ST_INIT) init_ptr_q <= init_ptr_q + IDX_W'(1);
      end
   end

   // Next state and the single PHT write port: init sweep has priority.
   always_comb begin
      state_d  = state_q;
      pht_we   = 1'b0;
      pht_widx = init_ptr_q;
      pht_wdat = CTR_WNT;
      case (state_q)
         ST_INIT: begin
            pht_we = 1'b1;
            if (init_ptr_q == IDX_LAST) state_d = ST_RUN;
         end
         ST_RUN: begin
            if (fire) begin
               pht_we   = 1'b1;
               pht_widx = rs_idx;
               pht_wdat = ctr_nxt;
            end
         end
         default: state_d = ST_INIT;
      endcase
   end

   // PHT storage; contents are defined by the init sweep, not by reset.
   always_ff @(posedge clk) begin
      if (pht_we) pht[pht_widx] <= pht_wdat;
   end

   // Registered lookup; same-cycle writes are not visible (read-before-write).
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) lk_taken <= 1'b0;
      else        lk_taken <= lk_valid & (state_q == ST_RUN) & pht[lk_idx][CTR_W-1];
   end

   // Mispredict pulse and the PC of the branch that caused it.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         mispredict <= 1'b0;
         mp_pc      <= '0;
      end else begin
         mispredict <= fire & wrong;
         if (fire) mp_pc <= rs_pc;
      end
   end

`ifdef BRANCH_STATS_EN
   // Saturating resolve / mispredict counters; clear beats increment.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         stat_resolved <= '0;
         stat_mispred  <= '0;
      end else if (stat_clr) begin
         stat_resolved <= '0;
         stat_mispred  <= '0;
      end else if (fire) begin
         if (stat_resolved != '1)  stat_resolved <= stat_resolved + 32'd1;
         if (wrong && stat_mispred != '1) stat_mispred <= stat_mispred + 32'd1;
      end
   end
`endif

endmodule
